// File: rtl/key_irq_queue_pkg.sv
// Shared constants, IRQ state type and read-word helper for key_irq_queue.
// Supplies the `Key_base bus address default when none is given.
`ifndef Key_base
`define Key_base 64'h0000_0000_FFFF_0100
`endif

package key_irq_queue_pkg;

    localparam logic [63:0] KEY_BASE     = `Key_base;
    localparam logic [3:0]  KEY_IRQ_CODE = 4'd1;
    localparam int          KEY_DEPTH    = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_ACKED
    } irq_state_e;

    function automatic logic [63:0] key_word(
        input logic [7:0] b,
        input logic       v,
        input logic       o
    );
        return {54'd0, o, v, b};
    endfunction

endpackage

// File: rtl/key_irq_queue_if.sv
// Key input, CPU bus and interrupt signals of key_irq_queue.
// master = CPU/decoder side, slave = the queue.
interface key_irq_queue_if #(
    parameter int DEPTH = 8
);
    logic [7:0]              key_ascii;
    logic                    key_pressed;
    logic [63:0]             bus_address;
    logic                    bus_read_enable;
    logic [63:0]             bus_read_data;
    logic                    key_sel;
    logic [3:0]              interrupt_vector;
    logic                    interrupt_ack;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output key_ascii, key_pressed, bus_address,
        output bus_read_enable, interrupt_ack,
        input  bus_read_data, key_sel, interrupt_vector, fifo_count
    );

    modport slave (
        input  key_ascii, key_pressed, bus_address,
        input  bus_read_enable, interrupt_ack,
        output bus_read_data, key_sel, interrupt_vector, fifo_count
    );
endinterface

// File: rtl/key_fifo.sv
// Byte FIFO with wrap-bit pointers; push while full succeeds only
// together with a pop. Entry RAM is not reset.
module key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             din_i,
    output logic [7:0]             dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                     (wr_q[AW] != rd_q[AW]);
    assign count_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
    assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; contents are meaningless after reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/key_irq_queue.sv
// PS/2 key queue with CPU read register and level interrupt handshake.
// Optional feature macro: KEY_OVERFLOW_FLAG_EN (sticky drop flag, bit 9).
module key_irq_queue
    import key_irq_queue_pkg::*;
#(
    parameter int          DEPTH    = KEY_DEPTH,
    parameter logic [63:0] KEY_ADDR = `Key_base,
    parameter logic [3:0]  IRQ_ID   = KEY_IRQ_CODE
) (
    input  logic           CLOCK_50,
    input  logic           KEY0,
    key_irq_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_q;
    logic          rd_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] count;
    logic          ovf;
    logic [63:0]   data_q, data_d;
    logic [3:0]    vec_q;
    irq_state_e    state_q;

    assign bus.key_sel          = (bus.bus_address == KEY_ADDR);
    assign bus.bus_read_data    = data_q;
    assign bus.interrupt_vector = vec_q;
    assign bus.fifo_count       = count;

    assign push = bus.key_pressed && !key_q &&
                  (bus.key_ascii != 8'd0);
    assign pop  = bus.key_sel && bus.bus_read_enable && !rd_q;

    assign data_d = key_word(fifo_empty ? 8'd0 : fifo_dout,
                             !fifo_empty, ovf);

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_ni  (KEY0),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.key_ascii),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (count)
    );

`ifdef KEY_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic drop;

    assign drop = push && fifo_full && !pop;
    assign ovf  = ovf_q;

    // Sticky drop flag, cleared by the read that reports it.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0)     ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
        else if (pop)  ovf_q <= 1'b0;
    end
`else
    logic unused_full;

    assign unused_full = fifo_full;
    assign ovf         = 1'b0;
`endif

    // Edge detects; key side starts high so a key held through
    // reset release is not taken as a press.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_q <= 1'b1;
            rd_q  <= 1'b0;
        end else begin
            key_q <= bus.key_pressed;
            rd_q  <= bus.key_sel && bus.bus_read_enable;
        end
    end

    // Read register, loaded once per CPU read strobe.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0)    data_q <= '0;
        else if (pop) data_q <= data_d;
    end

    // Interrupt request/acknowledge handshake with registered vector.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= IRQ_IDLE;
            vec_q   <= 4'd0;
        end else begin
            unique case (state_q)
                IRQ_IDLE: begin
                    if (count != '0) begin
                        state_q <= IRQ_REQ;
                        vec_q   <= IRQ_ID;
                    end
                end
                IRQ_REQ: begin
                    if (bus.interrupt_ack) begin
                        state_q <= IRQ_ACKED;
                        vec_q   <= 4'd0;
                    end
                end
                IRQ_ACKED: begin
                    if (!bus.interrupt_ack) state_q <= IRQ_IDLE;
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    vec_q   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_irq_queue.sv
// Directed bench for key_irq_queue (DEPTH = 8).
// Expected words account for KEY_OVERFLOW_FLAG_EN when defined.
module tb_key_irq_queue;
    import key_irq_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] d;
    logic [63:0] exp_w;

    key_irq_queue_if #(.DEPTH(8)) ifc ();

    key_irq_queue #(.DEPTH(8)) dut (
        .CLOCK_50 (clk),
        .KEY0     (rst_n),
        .bus      (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        ifc.key_ascii   = b;
        ifc.key_pressed = 1'b1;
        tick();
        ifc.key_pressed = 1'b0;
        ifc.key_ascii   = 8'd0;
        tick();
    endtask

    task automatic rd(output logic [63:0] v);
        ifc.bus_address     = KEY_BASE;
        ifc.bus_read_enable = 1'b1;
        tick();
        ifc.bus_read_enable = 1'b0;
        ifc.bus_address     = 64'd0;
        tick();
        v = ifc.bus_read_data;
    endtask

    task automatic ack_cycle();
        ifc.interrupt_ack = 1'b1;
        tick();
        ifc.interrupt_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        ifc.key_ascii       = 8'd0;
        ifc.key_pressed     = 1'b0;
        ifc.bus_address     = 64'd0;
        ifc.bus_read_enable = 1'b0;
        ifc.interrupt_ack   = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(ifc.fifo_count), 64'd0);
        chk("rst_vec", 64'(ifc.interrupt_vector), 64'd0);
        chk("rst_data", ifc.bus_read_data, 64'd0);
        chk("sel_off", 64'(ifc.key_sel), 64'd0);
        rst_n = 1'b1;
        tick();
        ifc.bus_address = KEY_BASE;
        #1;
        chk("sel_on", 64'(ifc.key_sel), 64'd1);
        ifc.bus_address = 64'd0;
        tick();

        // single key 'a'
        ifc.key_ascii   = 8'h61;
        ifc.key_pressed = 1'b1;
        tick();
        chk("a_count", 64'(ifc.fifo_count), 64'd1);
        chk("a_vec0", 64'(ifc.interrupt_vector), 64'd0);
        ifc.key_pressed = 1'b0;
        ifc.key_ascii   = 8'd0;
        tick();
        chk("a_vec1", 64'(ifc.interrupt_vector), 64'd1);
        rd(d);
        chk("a_read", d, 64'h161);
        chk("a_count0", 64'(ifc.fifo_count), 64'd0);
        ifc.interrupt_ack = 1'b1;
        tick();
        chk("a_ack", 64'(ifc.interrupt_vector), 64'd0);
        ifc.interrupt_ack = 1'b0;
        tick();
        tick();
        chk("a_idle", 64'(ifc.interrupt_vector), 64'd0);

        // zero byte is ignored
        ifc.key_pressed = 1'b1;
        tick();
        chk("zero_key", 64'(ifc.fifo_count), 64'd0);
        ifc.key_pressed = 1'b0;
        tick();

        // long strobe pops once
        press(8'h78);
        press(8'h79);
        press(8'h7a);
        ifc.bus_address     = KEY_BASE;
        ifc.bus_read_enable = 1'b1;
        repeat (100) tick();
        chk("hold_count", 64'(ifc.fifo_count), 64'd2);
        chk("hold_data", ifc.bus_read_data, 64'h178);
        ifc.bus_read_enable = 1'b0;
        ifc.bus_address     = 64'd0;
        tick();
        rd(d);
        chk("hold_rd2", d, 64'h179);
        rd(d);
        chk("hold_rd3", d, 64'h17a);
        rd(d);
        chk("empty_rd", d, 64'h000);
        chk("empty_cnt", 64'(ifc.fifo_count), 64'd0);
        ack_cycle();
        chk("clr_vec", 64'(ifc.interrupt_vector), 64'd0);

        // re-interrupt with keys left unread
        press(8'h31);
        press(8'h32);
        chk("re_vec1", 64'(ifc.interrupt_vector), 64'd1);
        ifc.interrupt_ack = 1'b1;
        tick();
        chk("re_ack", 64'(ifc.interrupt_vector), 64'd0);
        tick();
        tick();
        chk("re_ackhold", 64'(ifc.interrupt_vector), 64'd0);
        ifc.interrupt_ack = 1'b0;
        tick();
        chk("re_idle", 64'(ifc.interrupt_vector), 64'd0);
        tick();
        chk("re_raise", 64'(ifc.interrupt_vector), 64'd1);
        rd(d);
        chk("re_rd1", d, 64'h131);
        rd(d);
        chk("re_rd2", d, 64'h132);
        ack_cycle();

        // overflow: 10 presses into 8 entries
        for (int i = 0; i < 10; i++) press(8'(8'h41 + i));
        chk("ovf_count", 64'(ifc.fifo_count), 64'd8);
        chk("ovf_vec", 64'(ifc.interrupt_vector), 64'd1);
        for (int i = 0; i < 8; i++) begin
            exp_w = 64'h141 + 64'(i);
`ifdef KEY_OVERFLOW_FLAG_EN
            if (i == 0) exp_w = exp_w | 64'h200;
`endif
            rd(d);
            chk($sformatf("ovf_rd%0d", i), d, exp_w);
        end
        rd(d);
        chk("ovf_rd8", d, 64'h000);

        // push and pop together while full
        for (int i = 0; i < 8; i++) press(8'(8'h50 + i));
        chk("full_count", 64'(ifc.fifo_count), 64'd8);
        ifc.key_ascii       = 8'h58;
        ifc.key_pressed     = 1'b1;
        ifc.bus_address     = KEY_BASE;
        ifc.bus_read_enable = 1'b1;
        tick();
        chk("pp_count", 64'(ifc.fifo_count), 64'd8);
        chk("pp_data", ifc.bus_read_data, 64'h150);
        ifc.key_pressed     = 1'b0;
        ifc.key_ascii       = 8'd0;
        ifc.bus_read_enable = 1'b0;
        ifc.bus_address     = 64'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            rd(d);
            chk($sformatf("pp_rd%0d", i), d, 64'h151 + 64'(i));
        end
        rd(d);
        chk("pp_empty", d, 64'h000);

        // reset mid-operation
        for (int i = 0; i < 5; i++) press(8'(8'h60 + i));
        rd(d);
        chk("mr_rd", d, 64'h160);
        chk("mr_vec", 64'(ifc.interrupt_vector), 64'd1);
        ifc.key_ascii   = 8'h33;
        ifc.key_pressed = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mr_count", 64'(ifc.fifo_count), 64'd0);
        chk("mr_vec0", 64'(ifc.interrupt_vector), 64'd0);
        chk("mr_data", ifc.bus_read_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("held_key", 64'(ifc.fifo_count), 64'd0);
        ifc.key_pressed = 1'b0;
        ifc.key_ascii   = 8'd0;
        tick();
        rd(d);
        chk("mr_rd0", d, 64'h000);
        press(8'h33);
        chk("mr_press", 64'(ifc.fifo_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
